// File: rtl/cu_pkg.sv
// Shared types and encodings for the multi-cycle RISC-V control unit.
// Optional feature macro: CU_JAL_EN (adds the JAL state; opcode 1101111 legal).
package cu_pkg;

  // FSM states; JAL exists only when the jump feature is built in.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BEQ    = 4'd9,
`ifdef CU_JAL_EN
    S_JAL    = 4'd10,
`endif
    S_FAULT  = 4'd15
  } state_t;

  // Opcodes (instruction[6:0]) understood by the dispatcher.
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_SD    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  // ALU operand A select.
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALU operand B select.
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ALU operation class.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Writeback / PC-update result select.
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // Full control word produced by the state decoder.
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       branch;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       retire;
    logic       fault;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = ctrl_t'(17'd0);

  // States that talk to memory and therefore stall on mem_ready.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_output_decoder.sv
// Pure state -> control-word decoder for the multi-cycle control unit.
// Handshake-dependent strobes (FETCH IRWrite/PCWrite, MEMWR Retire) are emitted
// unconditionally here and qualified with mem_ready by the top level.
// Optional feature macro: CU_JAL_EN.
module mc_output_decoder
  import cu_pkg::*;
(
  input  state_t state_i,
  output ctrl_t  ctrl_o
);

  // Decode the current state into datapath controls; unlisted fields stay 0.
  always_comb begin
    ctrl_o = CTRL_NONE;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.adr_src    = 1'b0;
        ctrl_o.ir_write   = 1'b1;
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.alu_src_a  = SRCA_PC;
        ctrl_o.alu_src_b  = SRCB_FOUR;
        ctrl_o.alu_op     = ALUOP_ADD;
        ctrl_o.result_src = RES_ALU;
      end
      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        ctrl_o.alu_src_a = SRCA_OLDPC;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl_o.alu_src_a = SRCA_RS1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl_o.adr_src  = 1'b1;
        ctrl_o.mem_read = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.result_src = RES_MEM;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.retire     = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.adr_src   = 1'b1;
        ctrl_o.mem_write = 1'b1;
        ctrl_o.retire    = 1'b1;
      end
      S_EXECR: begin
        ctrl_o.alu_src_a = SRCA_RS1;
        ctrl_o.alu_src_b = SRCB_RS2;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ctrl_o.alu_src_a = SRCA_RS1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.retire     = 1'b1;
      end
      S_BEQ: begin
        ctrl_o.alu_src_a  = SRCA_RS1;
        ctrl_o.alu_src_b  = SRCB_RS2;
        ctrl_o.alu_op     = ALUOP_SUB;
        ctrl_o.branch     = 1'b1;
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.retire     = 1'b1;
      end
`ifdef CU_JAL_EN
      S_JAL: begin
        // Link value PC+4 goes to ALUOut while the PC takes the target.
        ctrl_o.alu_src_a  = SRCA_OLDPC;
        ctrl_o.alu_src_b  = SRCB_FOUR;
        ctrl_o.alu_op     = ALUOP_ADD;
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.result_src = RES_ALUOUT;
      end
`endif
      S_FAULT: begin
        ctrl_o.fault = 1'b1;
      end
      default: begin
        // Unreachable encodings look like a fault so nothing gets written.
        ctrl_o.fault = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RISC-V control FSM: fetch/decode/execute/memory/writeback
// sequencing with a mem_ready stall handshake, a memory wait-timeout, and a
// sticky FAULT state for illegal opcodes or timeouts.
// Optional feature macro: CU_JAL_EN (enables the jal path).
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
)(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] Opcode,
  input  logic       mem_ready,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       Branch,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ResultSrc,
  output logic       Retire,
  output logic       Fault
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic             TO_EN     = (TIMEOUT > 32'sd0);

  state_t           state_q, state_d, nxt_s;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_s;
  logic             mem_state_s, timeout_s, mealy_ok_s, en_s;
  ctrl_t            ctrl_s;

  // Next-state dispatch, memory-wait counter and timeout detection.
  always_comb begin
    nxt_s       = state_q;
    mem_state_s = is_mem_state(state_q);
    cnt_inc_s   = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_W'(1));
    // mem_ready in the same cycle always wins over an expiring counter.
    timeout_s   = TO_EN && mem_state_s && !mem_ready && (cnt_inc_s >= TIMEOUT_C);

    case (state_q)
      S_FETCH: begin
        if (mem_ready) nxt_s = S_DECODE;
        else           nxt_s = S_FETCH;
      end
      S_DECODE: begin
        case (Opcode)
          OP_LD, OP_SD: nxt_s = S_MEMADR;
          OP_RTYPE:     nxt_s = S_EXECR;
          OP_ITYPE:     nxt_s = S_EXECI;
          OP_BEQ:       nxt_s = S_BEQ;
`ifdef CU_JAL_EN
          OP_JAL:       nxt_s = S_JAL;
`endif
          default:      nxt_s = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        if (Opcode == OP_LD)      nxt_s = S_MEMRD;
        else if (Opcode == OP_SD) nxt_s = S_MEMWR;
        else                      nxt_s = S_FAULT;
      end
      S_MEMRD: begin
        if (mem_ready) nxt_s = S_MEMWB;
        else           nxt_s = S_MEMRD;
      end
      S_MEMWB: nxt_s = S_FETCH;
      S_MEMWR: begin
        if (mem_ready) nxt_s = S_FETCH;
        else           nxt_s = S_MEMWR;
      end
      S_EXECR: nxt_s = S_ALUWB;
      S_EXECI: nxt_s = S_ALUWB;
      S_ALUWB: nxt_s = S_FETCH;
      S_BEQ:   nxt_s = S_FETCH;
`ifdef CU_JAL_EN
      S_JAL:   nxt_s = S_ALUWB;
`endif
      S_FAULT: nxt_s = S_FAULT;
      default: nxt_s = S_FAULT;
    endcase

    state_d = timeout_s ? S_FAULT : nxt_s;

    // Any state change (incl. entry into a memory state) or a completed
    // access restarts the count; only stalled memory cycles advance it.
    if (mem_ready || (state_d != state_q)) cnt_d = CNT_ZERO;
    else if (mem_state_s)                  cnt_d = cnt_inc_s;
    else                                   cnt_d = cnt_q;
  end

  // State register and wait counter with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  mc_output_decoder u_dec (
    .state_i (state_q),
    .ctrl_o  (ctrl_s)
  );

  // Qualify handshake strobes with mem_ready and suppress enables under reset.
  always_comb begin
    en_s       = ~reset;
    if ((state_q == S_FETCH) || (state_q == S_MEMWR)) mealy_ok_s = mem_ready;
    else                                              mealy_ok_s = 1'b1;

    MemRead   = ctrl_s.mem_read  & en_s;
    MemWrite  = ctrl_s.mem_write & en_s;
    IRWrite   = ctrl_s.ir_write  & mealy_ok_s & en_s;
    PCWrite   = ctrl_s.pc_write  & mealy_ok_s & en_s;
    RegWrite  = ctrl_s.reg_write & en_s;
    Branch    = ctrl_s.branch    & en_s;
    Retire    = ctrl_s.retire    & mealy_ok_s & en_s;
    Fault     = ctrl_s.fault     & en_s;
    AdrSrc    = ctrl_s.adr_src;
    ALUSrcA   = ctrl_s.alu_src_a;
    ALUSrcB   = ctrl_s.alu_src_b;
    ALUOp     = ctrl_s.alu_op;
    ResultSrc = ctrl_s.result_src;
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit (TIMEOUT=4).
// Each cycle compares the full 17-bit control word against a hand-written
// vector: {MemRead,MemWrite,AdrSrc,IRWrite,PCWrite,RegWrite,Branch,
//          ALUSrcA,ALUSrcB,ALUOp,ResultSrc,Retire,Fault}.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] Opcode;
  logic       mem_ready;
  logic       MemRead, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, Branch;
  logic [1:0] ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
  logic       Retire, Fault;
  logic [16:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [16:0] V_RST    = 17'b0_0_0_0_0_0_0_00_10_00_10_0_0;
  localparam logic [16:0] V_ZERO   = 17'b0_0_0_0_0_0_0_00_00_00_00_0_0;
  localparam logic [16:0] V_FETCH  = 17'b1_0_0_1_1_0_0_00_10_00_10_0_0;
  localparam logic [16:0] V_FSTALL = 17'b1_0_0_0_0_0_0_00_10_00_10_0_0;
  localparam logic [16:0] V_DECODE = 17'b0_0_0_0_0_0_0_01_01_00_00_0_0;
  localparam logic [16:0] V_MEMADR = 17'b0_0_0_0_0_0_0_10_01_00_00_0_0;
  localparam logic [16:0] V_MEMRD  = 17'b1_0_1_0_0_0_0_00_00_00_00_0_0;
  localparam logic [16:0] V_MEMWB  = 17'b0_0_0_0_0_1_0_00_00_00_01_1_0;
  localparam logic [16:0] V_MEMWR  = 17'b0_1_1_0_0_0_0_00_00_00_00_1_0;
  localparam logic [16:0] V_WSTALL = 17'b0_1_1_0_0_0_0_00_00_00_00_0_0;
  localparam logic [16:0] V_RSTWR  = 17'b0_0_1_0_0_0_0_00_00_00_00_0_0;
  localparam logic [16:0] V_EXECR  = 17'b0_0_0_0_0_0_0_10_00_10_00_0_0;
  localparam logic [16:0] V_EXECI  = 17'b0_0_0_0_0_0_0_10_01_10_00_0_0;
  localparam logic [16:0] V_ALUWB  = 17'b0_0_0_0_0_1_0_00_00_00_00_1_0;
  localparam logic [16:0] V_BEQ    = 17'b0_0_0_0_0_0_1_10_00_01_00_1_0;
  localparam logic [16:0] V_JAL    = 17'b0_0_0_0_1_0_0_01_10_00_00_0_0;
  localparam logic [16:0] V_FAULT  = 17'b0_0_0_0_0_0_0_00_00_00_00_0_1;

  multicycle_control_unit #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .Opcode    (Opcode),
    .mem_ready (mem_ready),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .AdrSrc    (AdrSrc),
    .IRWrite   (IRWrite),
    .PCWrite   (PCWrite),
    .RegWrite  (RegWrite),
    .Branch    (Branch),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .ResultSrc (ResultSrc),
    .Retire    (Retire),
    .Fault     (Fault)
  );

  assign obs = {MemRead, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, Branch,
                ALUSrcA, ALUSrcB, ALUOp, ResultSrc, Retire, Fault};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // One clock: drive inputs just after the edge, compare on the falling edge.
  task automatic cyc(input logic rst, input logic mr, input logic [16:0] exp, input string tag);
    reset     = rst;
    mem_ready = mr;
    @(negedge clk);
    check(tag, obs, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b0;
    Opcode    = 7'b0000000;
    repeat (2) @(posedge clk);
    #1;
    cyc(1'b1, 1'b1, V_RST, "reset_fetch");

    // R-type, zero wait: 4 cycles, RegWrite/Retire only in the last.
    Opcode = 7'b0110011;
    cyc(1'b0, 1'b1, V_FETCH,  "r_fetch");
    cyc(1'b0, 1'b1, V_DECODE, "r_decode");
    cyc(1'b0, 1'b1, V_EXECR,  "r_execr");
    cyc(1'b0, 1'b1, V_ALUWB,  "r_aluwb");

    // ld with 3 stall cycles in MEMRD (the 4th cycle hits TIMEOUT but ready wins).
    Opcode = 7'b0000011;
    cyc(1'b0, 1'b1, V_FETCH,  "ld_fetch");
    cyc(1'b0, 1'b1, V_DECODE, "ld_decode");
    cyc(1'b0, 1'b1, V_MEMADR, "ld_memadr");
    cyc(1'b0, 1'b0, V_MEMRD,  "ld_memrd_w1");
    cyc(1'b0, 1'b0, V_MEMRD,  "ld_memrd_w2");
    cyc(1'b0, 1'b0, V_MEMRD,  "ld_memrd_w3");
    cyc(1'b0, 1'b1, V_MEMRD,  "ld_memrd_rdy");
    cyc(1'b0, 1'b1, V_MEMWB,  "ld_memwb");

    // sd with one stall: Retire only together with mem_ready.
    Opcode = 7'b0100011;
    cyc(1'b0, 1'b1, V_FETCH,  "sd_fetch");
    cyc(1'b0, 1'b1, V_DECODE, "sd_decode");
    cyc(1'b0, 1'b1, V_MEMADR, "sd_memadr");
    cyc(1'b0, 1'b0, V_WSTALL, "sd_memwr_wait");
    cyc(1'b0, 1'b1, V_MEMWR,  "sd_memwr_rdy");

    // I-type after three fetch stalls (counter must clear before MEMRD later).
    Opcode = 7'b0010011;
    cyc(1'b0, 1'b0, V_FSTALL, "i_fetch_w1");
    cyc(1'b0, 1'b0, V_FSTALL, "i_fetch_w2");
    cyc(1'b0, 1'b0, V_FSTALL, "i_fetch_w3");
    cyc(1'b0, 1'b1, V_FETCH,  "i_fetch_rdy");
    cyc(1'b0, 1'b1, V_DECODE, "i_decode");
    cyc(1'b0, 1'b1, V_EXECI,  "i_execi");
    cyc(1'b0, 1'b1, V_ALUWB,  "i_aluwb");

    // beq: 3 cycles.
    Opcode = 7'b1100011;
    cyc(1'b0, 1'b1, V_FETCH,  "beq_fetch");
    cyc(1'b0, 1'b1, V_DECODE, "beq_decode");
    cyc(1'b0, 1'b1, V_BEQ,    "beq_exec");

    // jal: legal only when built with the jump feature.
    Opcode = 7'b1101111;
    cyc(1'b0, 1'b1, V_FETCH,  "jal_fetch");
    cyc(1'b0, 1'b1, V_DECODE, "jal_decode");
`ifdef CU_JAL_EN
    cyc(1'b0, 1'b1, V_JAL,    "jal_jal");
    cyc(1'b0, 1'b1, V_ALUWB,  "jal_aluwb");
    cyc(1'b1, 1'b1, V_RST,    "jal_reset");
`else
    cyc(1'b0, 1'b1, V_FAULT,  "jal_fault");
    cyc(1'b0, 1'b1, V_FAULT,  "jal_fault_hold");
    cyc(1'b1, 1'b1, V_ZERO,   "jal_reset");
`endif

    // Illegal opcode: sticky FAULT even once a legal opcode appears.
    Opcode = 7'b1111111;
    cyc(1'b0, 1'b1, V_FETCH,  "ill_fetch");
    cyc(1'b0, 1'b1, V_DECODE, "ill_decode");
    Opcode = 7'b0110011;
    cyc(1'b0, 1'b1, V_FAULT,  "ill_fault1");
    cyc(1'b0, 1'b1, V_FAULT,  "ill_fault2");
    cyc(1'b0, 1'b0, V_FAULT,  "ill_fault3");
    cyc(1'b1, 1'b1, V_ZERO,   "ill_reset");

    // Reset in the middle of a store drops MemWrite and Retire.
    Opcode = 7'b0100011;
    cyc(1'b0, 1'b1, V_FETCH,  "rst_sd_fetch");
    cyc(1'b0, 1'b1, V_DECODE, "rst_sd_decode");
    cyc(1'b0, 1'b1, V_MEMADR, "rst_sd_memadr");
    cyc(1'b1, 1'b1, V_RSTWR,  "rst_sd_memwr");
    cyc(1'b0, 1'b1, V_FETCH,  "rst_sd_refetch");
    cyc(1'b1, 1'b0, V_DECODE, "rst_in_decode");

    // Fetch timeout: 4 stalled cycles then FAULT.
    cyc(1'b0, 1'b0, V_FSTALL, "to_fetch_w1");
    cyc(1'b0, 1'b0, V_FSTALL, "to_fetch_w2");
    cyc(1'b0, 1'b0, V_FSTALL, "to_fetch_w3");
    cyc(1'b0, 1'b0, V_FSTALL, "to_fetch_w4");
    cyc(1'b0, 1'b1, V_FAULT,  "to_fetch_fault");
    cyc(1'b0, 1'b1, V_FAULT,  "to_fetch_hold");
    cyc(1'b1, 1'b0, V_ZERO,   "to_reset");

    // Load timeout in MEMRD.
    Opcode = 7'b0000011;
    cyc(1'b0, 1'b1, V_FETCH,  "tord_fetch");
    cyc(1'b0, 1'b1, V_DECODE, "tord_decode");
    cyc(1'b0, 1'b0, V_MEMADR, "tord_memadr");
    cyc(1'b0, 1'b0, V_MEMRD,  "tord_w1");
    cyc(1'b0, 1'b0, V_MEMRD,  "tord_w2");
    cyc(1'b0, 1'b0, V_MEMRD,  "tord_w3");
    cyc(1'b0, 1'b0, V_MEMRD,  "tord_w4");
    cyc(1'b0, 1'b1, V_FAULT,  "tord_fault");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
